// File: rtl/avg_write_sequencer.sv
// Averaging-opcode to bank write-enable sequencer: issues one group mask per
// accepted beat, either a single group or a sweep up to the last group.
module avg_write_sequencer #(
    parameter int OPW         = 6,
    parameter int NUM_BANKS   = 16,
    parameter int GROUP       = 3,
    parameter int BASE_OPCODE = 32,
    localparam int NUM_GROUPS = (NUM_BANKS + GROUP - 1) / GROUP,
    localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [OPW-1:0]       i_opcode,
    input  logic                 i_sweep,
    input  logic                 i_ready,
    input  logic                 i_flush,
    output logic [NUM_BANKS-1:0] o_selWrite,
    output logic                 o_valid,
    output logic [GW-1:0]        o_group,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [GW-1:0] LAST_G = GW'(NUM_GROUPS - 1);

    state_t                 state_q, state_d;
    logic [GW-1:0]          group_q, group_d;
    logic                   sweep_q, sweep_d;
    logic [NUM_BANKS-1:0]   sel_q, sel_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [OPW:0]           diff;
    logic                   legal;
    logic [GW-1:0]          idx;

    // Banks of the last group beyond NUM_BANKS-1 simply do not exist.
    function automatic logic [NUM_BANKS-1:0] group_mask(input logic [GW-1:0] g);
        logic [NUM_BANKS-1:0] m;
        for (int b = 0; b < NUM_BANKS; b++) begin
            m[b] = ((b / GROUP) == int'(g));
        end
        return m;
    endfunction

    // One extra bit so an opcode below the base wraps to a large value.
    assign diff  = {1'b0, i_opcode} - (OPW+1)'(BASE_OPCODE);
    assign legal = (diff < (OPW+1)'(NUM_GROUPS));
    assign idx   = diff[GW-1:0];

    always_comb begin
        state_d = state_q;
        group_d = group_q;
        sweep_d = sweep_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_flush && i_start) begin
                    if (legal) begin
                        state_d = ISSUE;
                        group_d = idx;
                        sweep_d = i_sweep;
                        sel_d   = group_mask(idx);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (i_flush) begin
                    state_d = IDLE;
                    group_d = '0;
                    sel_d   = '0;
                end else if (i_ready) begin
                    if (sweep_q && (group_q < LAST_G)) begin
                        group_d = group_q + GW'(1);
                        sel_d   = group_mask(group_q + GW'(1));
                    end else begin
                        state_d = IDLE;
                        group_d = '0;
                        sel_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                group_d = '0;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            group_q <= '0;
            sweep_q <= 1'b0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
            sweep_q <= sweep_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_selWrite = sel_q;
    assign o_valid    = (state_q == ISSUE);
    assign o_busy     = (state_q == ISSUE);
    assign o_group    = group_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_avg_write_sequencer.sv
// Directed bench for avg_write_sequencer: a per-cycle vector table on the
// default configuration plus hand sequences for reset-in-ISSUE and an 8-bank build.
module tb_avg_write_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, sweep, ready, flush;
    logic [5:0]  opcode;

    logic [15:0] sel;
    logic        valid, busy, done, err;
    logic [2:0]  grp;

    logic [7:0]  sel2;
    logic        valid2, busy2, done2, err2;
    logic [0:0]  grp2;

    int errors = 0;
    int checks = 0;
    int row    = 0;

    always #5 clk = ~clk;

    avg_write_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_opcode(opcode),
        .i_sweep(sweep), .i_ready(ready), .i_flush(flush),
        .o_selWrite(sel), .o_valid(valid), .o_group(grp),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    avg_write_sequencer #(.NUM_BANKS(8), .GROUP(4), .BASE_OPCODE(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_opcode(opcode),
        .i_sweep(sweep), .i_ready(ready), .i_flush(flush),
        .o_selWrite(sel2), .o_valid(valid2), .o_group(grp2),
        .o_busy(busy2), .o_done(done2), .o_err(err2)
    );

    typedef struct {
        logic        rst, start, sweep, ready, flush;
        logic [5:0]  op;
        logic [15:0] sel;
        logic        valid;
        logic [2:0]  grp;
        logic        busy, done, err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input int r, input int s, input int sw, input int rd,
                               input int fl, input int op, input int esel,
                               input int evl, input int eg, input int eb,
                               input int ed, input int ee);
        vec_t x;
        x.rst = r[0];   x.start = s[0]; x.sweep = sw[0]; x.ready = rd[0];
        x.flush = fl[0]; x.op = op[5:0];
        x.sel = esel[15:0]; x.valid = evl[0]; x.grp = eg[2:0];
        x.busy = eb[0]; x.done = ed[0]; x.err = ee[0];
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic sw, input logic rd,
                         input logic fl, input logic [5:0] op);
        rst = r; start = s; sweep = sw; ready = rd; flush = fl; opcode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input logic [15:0] esel, input logic evl, input logic [2:0] eg,
                            input logic eb, input logic ed, input logic ee);
        chk("selWrite", 32'(sel), 32'(esel));
        chk("valid", 32'(valid), 32'(evl));
        chk("group", 32'(grp), 32'(eg));
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
        chk("err", 32'(err), 32'(ee));
    endtask

    task automatic chk_small(input logic [7:0] esel, input logic evl, input logic eg,
                             input logic eb, input logic ed, input logic ee);
        chk("selWrite2", 32'(sel2), 32'(esel));
        chk("valid2", 32'(valid2), 32'(evl));
        chk("group2", 32'(grp2), 32'(eg));
        chk("busy2", 32'(busy2), 32'(eb));
        chk("done2", 32'(done2), 32'(ed));
        chk("err2", 32'(err2), 32'(ee));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sweep = 1'b0; ready = 1'b0; flush = 1'b0; opcode = '0;

        //             rst st sw rd fl  op   sel    vl g  bz dn er
        tbl.push_back(v(1, 0, 0, 0, 0,  0, 'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,  0, 'h0000, 0, 0, 0, 0, 0));
        // single beat, group 0
        tbl.push_back(v(0, 1, 0, 1, 0, 32, 'h0007, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h0000, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,  0, 'h0000, 0, 0, 0, 0, 0));
        // clipped last group, then a middle group
        tbl.push_back(v(0, 1, 0, 0, 0, 37, 'h8000, 1, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h0000, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 35, 'h0E00, 1, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h0000, 0, 0, 0, 1, 0));
        // sweep from group 2 with ready 1,0,1,1,0,1
        tbl.push_back(v(0, 1, 1, 0, 0, 34, 'h01C0, 1, 2, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h0E00, 1, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,  0, 'h0E00, 1, 3, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h7000, 1, 4, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h8000, 1, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,  0, 'h8000, 1, 5, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h0000, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,  0, 'h0000, 0, 0, 0, 0, 0));
        // illegal opcodes above and below the legal range
        tbl.push_back(v(0, 1, 0, 1, 0, 38, 'h0000, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 31, 'h0000, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h0000, 0, 0, 0, 0, 0));
        // sweep from 0, start while busy ignored, flush beats handshake
        tbl.push_back(v(0, 1, 1, 0, 0, 32, 'h0007, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 36, 'h0038, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0,  0, 'h01C0, 1, 2, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1,  0, 'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,  0, 'h0000, 0, 0, 0, 0, 0));
        // flush in IDLE suppresses legal and illegal starts
        tbl.push_back(v(0, 1, 0, 1, 1, 32, 'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 1, 40, 'h0000, 0, 0, 0, 0, 0));
        // start coincident with the final handshake is ignored
        tbl.push_back(v(0, 1, 0, 0, 0, 33, 'h0038, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 32, 'h0000, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0,  0, 'h0000, 0, 0, 0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            row = i;
            drive(tbl[i].rst, tbl[i].start, tbl[i].sweep, tbl[i].ready, tbl[i].flush, tbl[i].op);
            chk_main(tbl[i].sel, tbl[i].valid, tbl[i].grp, tbl[i].busy, tbl[i].done, tbl[i].err);
        end

        // reset while a beat is stalled
        row = 100;
        drive(0, 1, 0, 0, 0, 6'd37);
        chk_main(16'h8000, 1, 3'd5, 1, 0, 0);
        row = 101;
        drive(1, 0, 0, 0, 0, 6'd0);
        chk_main(16'h0000, 0, 3'd0, 0, 0, 0);
        chk_small(8'h00, 0, 1'b0, 0, 0, 0);

        // 8-bank, 4-per-group build, base opcode 0
        row = 200;
        drive(0, 1, 0, 0, 0, 6'd1);
        chk_small(8'hF0, 1, 1'b1, 1, 0, 0);
        row = 201;
        drive(0, 0, 0, 0, 0, 6'd0);
        chk_small(8'hF0, 1, 1'b1, 1, 0, 0);
        row = 202;
        drive(1, 0, 0, 0, 0, 6'd0);
        chk_small(8'h00, 0, 1'b0, 0, 0, 0);
        row = 203;
        drive(0, 1, 0, 0, 0, 6'd1);
        chk_small(8'hF0, 1, 1'b1, 1, 0, 0);
        row = 204;
        drive(0, 0, 0, 1, 0, 6'd0);
        chk_small(8'h00, 0, 1'b0, 0, 1, 0);
        row = 205;
        drive(0, 1, 0, 1, 0, 6'd2);
        chk_small(8'h00, 0, 1'b0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
